rtc_display_scanner: RTL
========================

Name: rtc_display_scanner

Overview:
- Downstream consumer of the RTC controller's register memory read port (4-bit read address out, 8-bit register data in).
- Periodically sweeps the time/date/timer registers into a double-buffered shadow and commits each sweep atomically.
- Serves individual BCD digits to the display/VGA text generator through a 1-cycle-latency character read port.
- Flags malformed BCD.

Parameters:
- NREG, 9: number of consecutive registers swept (sec, min, hour, day, month, year, timer sec/min/hour); legal range 1..16.
- BASE_ADDR, 0: read address of the first swept register; BASE_ADDR+NREG-1 must be ≤ 15.
- RD_LAT, 1: clock cycles from rd_addr change to valid rd_data; legal range 1..3.
- BLINK_DIV, 25000000: clk cycles per cursor blink half-period; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- refresh_tick  in  1  single-cycle sweep request
- rd_addr  out  4  register read address to the controller memory
- rd_data  in  8  register contents (packed BCD, tens in [7:4], units in [3:0])
- char_idx  in  5  digit index requested by the display
- char_bcd  out  4  digit value for char_idx, registered
- frame_valid  out  1  high once the first sweep has committed
- frame_done  out  1  one-cycle pulse on each commit
- busy  out  1  sweep in progress
- bcd_err  out  1  last committed frame contained a nibble > 9
- cursor  in  4  register index currently edited by the user, from the controller pointer

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rd_addr=BASE_ADDR; char_bcd=0; frame_valid=0; frame_done=0; busy=0; bcd_err=0.
  - Work and display buffers cleared to 0; pending flag cleared.
  - Reset asserted mid-sweep discards the partial work buffer; no commit occurs.
- FSM:
  - IDLE: on refresh_tick or pending → rd_addr=BASE_ADDR, idx=0, clear pending and work error flag, busy=1 → WAIT.
  - WAIT: count RD_LAT cycles → CAPTURE.
  - CAPTURE: work[idx]←rd_data. Set work error flag if rd_data[7:4]>9 or rd_data[3:0]>9. If idx==NREG-1 → COMMIT; else idx+1, rd_addr+1 → WAIT.
  - COMMIT: copy work buffer to display buffer in one cycle; bcd_err←work error flag; frame_valid←1; frame_done=1 for this cycle only; busy=0 → IDLE.
- Sweep length: exactly NREG*(RD_LAT+1)+1 cycles from the tick edge to the frame_done pulse. NREG=9, RD_LAT=1 gives 19 cycles.
- refresh_tick during busy (including the COMMIT cycle): sets pending. Multiple ticks collapse into one pending. The next sweep starts on the cycle after COMMIT.
- rd_addr is held stable throughout WAIT and CAPTURE; it changes only on the IDLE→WAIT and CAPTURE→WAIT transitions.
- Character port, registered with 1-cycle latency:
  - Index i = char_idx[4:1]. Even char_idx returns display[i][7:4]; odd returns display[i][3:0].
  - char_idx ≥ 2*NREG returns 4'hF (blank code).
  - A stored nibble > 9 returns 4'hE (error glyph) in place of its value.
  - Reads always see the display buffer, never the work buffer. A COMMIT and a read in the same cycle return the pre-commit value; the next cycle returns the new value.
- frame_valid stays low until the first commit; the display treats char_bcd as blank while frame_valid=0.

Optional Feature:
- Macro: RTC_CURSOR_BLINK_EN.
- Defined:
  - A free-running counter toggles a blink phase every BLINK_DIV cycles; counter and phase reset to 0.
  - While phase=1, both digits of register index cursor return 4'hF.
  - cursor ≥ NREG has no effect.
- Undefined: no counter, no phase; the cursor input is ignored and char_bcd is never blanked by the cursor.

Test Plan:
- Reset release, memory holding 8'h59,8'h30,8'h23,… with NREG=9, RD_LAT=1: pulse tick → rd_addr steps 0..8; frame_done pulses exactly 19 cycles after the tick; frame_valid=1; char_idx=0 → char_bcd=5 next cycle; char_idx=1 → 9.
- Register 2 = 8'h3A, sweep → bcd_err=1; char_idx=5 → 4'hE; fix register to 8'h12 and sweep again → bcd_err=0, char_idx=5 → 2.
- Three ticks during a sweep → exactly one extra sweep follows; frame_done pulses twice in total.
- Change register 0 from 8'h59 to 8'h00 mid-sweep (after capture); keep reading char_idx=0 every cycle → output stays 5 until the cycle after COMMIT, then shows the new committed value on the next sweep. No torn frame is ever visible.
- Assert reset at cycle 7 of a sweep → all outputs return to reset values immediately; buffers cleared; frame_valid=0; the next tick starts a fresh sweep at BASE_ADDR.
- RTC_CURSOR_BLINK_EN defined, BLINK_DIV=4, cursor=1: char_idx=2,3 alternate between the real digits and 4'hF every 4 cycles; char_idx=0 is unaffected. cursor=12 → no blanking. Macro undefined → no blanking for any cursor value.

Source files
------------

// File: rtl/rtc_display_scanner.sv
// Sweeps NREG RTC registers into a work buffer and commits them atomically to a display shadow; serves BCD digits.
// Latency: sweep is NREG*(RD_LAT+1)+1 cycles tick-to-frame_done; character port answers one cycle after char_idx.
// Backpressure: none; ticks arriving mid-sweep collapse into one pending sweep. Optional blink: RTC_CURSOR_BLINK_EN.
module rtc_display_scanner #(
    parameter int NREG      = 9,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    output logic [3:0] rd_addr,
    input  logic [7:0] rd_data,
    input  logic [4:0] char_idx,
    output logic [3:0] char_bcd,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       busy,
    output logic       bcd_err,
    input  logic [3:0] cursor
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, COMMIT} state_t;

    localparam logic [3:0] BASE4    = 4'(BASE_ADDR);
    localparam logic [3:0] LAST_IDX = 4'(NREG - 1);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [5:0] NCHAR    = 6'(2 * NREG);

    state_t     state_q;
    logic [3:0] rd_addr_q;
    logic [3:0] idx_q;
    logic [1:0] lat_q;
    logic       pending_q;
    logic       werr_q;
    logic       frame_valid_q;
    logic       frame_done_q;
    logic       busy_q;
    logic       bcd_err_q;
    logic [7:0] work_q [NREG];
    logic [7:0] disp_q [NREG];
    logic [3:0] char_bcd_q;
    logic [3:0] char_bcd_d;
    logic       blank_w;

    // Sweep sequencer: walks the read address, captures into the work buffer, commits the whole frame at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rd_addr_q     <= BASE4;
            idx_q         <= 4'd0;
            lat_q         <= 2'd0;
            pending_q     <= 1'b0;
            werr_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            bcd_err_q     <= 1'b0;
            for (int k = 0; k < NREG; k++) begin
                work_q[k] <= 8'h00;
                disp_q[k] <= 8'h00;
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (refresh_tick || pending_q) begin
                        rd_addr_q <= BASE4;
                        idx_q     <= 4'd0;
                        lat_q     <= 2'd0;
                        pending_q <= 1'b0;
                        werr_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (refresh_tick) pending_q <= 1'b1;
                    if (lat_q == LAT_LAST) state_q <= CAPTURE;
                    else                   lat_q   <= lat_q + 2'd1;
                end
                CAPTURE: begin
                    if (refresh_tick) pending_q <= 1'b1;
                    for (int k = 0; k < NREG; k++) begin
                        if (4'(k) == idx_q) work_q[k] <= rd_data;
                    end
                    if (rd_data[7:4] > 4'd9 || rd_data[3:0] > 4'd9) werr_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q     <= idx_q + 4'd1;
                        rd_addr_q <= rd_addr_q + 4'd1;
                        lat_q     <= 2'd0;
                        state_q   <= WAIT;
                    end
                end
                COMMIT: begin
                    // A tick landing on the commit edge still counts as a request for another sweep.
                    if (refresh_tick) pending_q <= 1'b1;
                    disp_q        <= work_q;
                    bcd_err_q     <= werr_q;
                    frame_valid_q <= 1'b1;
                    frame_done_q  <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RTC_CURSOR_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [4:0]    NREG5      = 5'(NREG);

    logic [BW-1:0] blink_cnt_q;
    logic          phase_q;

    // Free-running blink timebase; phase flips every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blank_w = phase_q && ({1'b0, cursor} < NREG5) && (cursor == char_idx[4:1]);
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor;
    assign blank_w       = 1'b0;
`endif

    // Digit lookup from the display buffer only; out-of-range and blinked digits are blank, bad nibbles show the error glyph.
    always_comb begin
        logic [7:0] sel;
        logic [3:0] nib;
        sel = 8'h00;
        for (int k = 0; k < NREG; k++) begin
            if (4'(k) == char_idx[4:1]) sel = disp_q[k];
        end
        nib = char_idx[0] ? sel[3:0] : sel[7:4];
        if ({1'b0, char_idx} >= NCHAR) char_bcd_d = 4'hF;
        else if (blank_w)              char_bcd_d = 4'hF;
        else if (nib > 4'd9)           char_bcd_d = 4'hE;
        else                           char_bcd_d = nib;
    end

    // Registered character port: a read on the commit edge still sees the old frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) char_bcd_q <= 4'h0;
        else        char_bcd_q <= char_bcd_d;
    end

    assign rd_addr     = rd_addr_q;
    assign char_bcd    = char_bcd_q;
    assign frame_valid = frame_valid_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign bcd_err     = bcd_err_q;

endmodule
